// File: rtl/avmm_timer_driver.sv
// rtl/avmm_timer_driver.sv - Avalon-MM initiator that programs and services an interval timer
//
// Purpose:
//    Writes the period and control registers of a 16-bit-register interval
//    timer when enable rises, then services each timeout: read status, clear
//    it, emit a one-cycle tick. Dropping enable writes STOP and returns to idle.
//    Build option: TIMER_DRV_POLL_EN (defined: irq ignored, ITO left off,
//    status polled every POLL_GAP idle cycles).
//
// Ports:
//    clk, reset_n          clock, asynchronous active-low reset
//    enable                level, high = run timer
//    irq                   timer interrupt (level)
//    avm_address           register address (0 status, 1 control, 2 period_l, 3 period_h)
//    avm_chipselect        bus command valid
//    avm_write_n           active-low write strobe
//    avm_read              read strobe
//    avm_writedata         write data
//    avm_readdata          read data, valid READ_LATENCY cycles after the read
//    tick                  one-cycle pulse per serviced timeout
//    tick_count            serviced-timeout count, wraps
//    running               high from control-write commit until stop-write commit
//    spurious              sticky, status.TO read as 0 while servicing

module avmm_timer_driver #(
   parameter logic [31:0] PERIOD       = 32'd24999,
   parameter logic [15:0] CTRL_RUN     = 16'h0007,
   parameter int          READ_LATENCY = 1,
   parameter int          TICK_W       = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              irq,
   output logic [2:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic              avm_read,
   output logic [15:0]       avm_writedata,
   input  logic [15:0]       avm_readdata,
   output logic              tick,
   output logic [TICK_W-1:0] tick_count,
   output logic              running,
   output logic              spurious
);

`ifdef TIMER_DRV_POLL_EN
   localparam logic [15:0] CTRL_INIT = CTRL_RUN & 16'hFFFE;
   localparam logic [1:0]  POLL_LAST = 2'd3;   // POLL_GAP = 4 idle cycles
`else
   localparam logic [15:0] CTRL_INIT = CTRL_RUN;
`endif
   localparam logic [15:0] CTRL_STOP = 16'h0008;
   localparam logic [1:0]  LAT_LAST  = 2'(READ_LATENCY - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WAIT,
      S_RD, S_RD_WAIT, S_CLR, S_WR_STOP
   } state_t;

   state_t     state;
   logic [1:0] lat_cnt;
`ifdef TIMER_DRV_POLL_EN
   logic [1:0] poll_cnt;
   logic       unused_irq;
   assign unused_irq = irq;
`else
   logic       holdoff;    // masks the stale irq seen in the cycle after CLR
`endif
   logic       unused_rd;
   assign unused_rd = ^avm_readdata[15:1];

   // Bus outputs are registered: each transition loads the command that the
   // destination state presents on the bus for its single cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         avm_address    <= 3'd0;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_read       <= 1'b0;
         avm_writedata  <= 16'h0000;
         tick           <= 1'b0;
         tick_count     <= '0;
         running        <= 1'b0;
         spurious       <= 1'b0;
         lat_cnt        <= 2'd0;
`ifdef TIMER_DRV_POLL_EN
         poll_cnt       <= 2'd0;
`else
         holdoff        <= 1'b0;
`endif
      end else begin
         avm_address    <= 3'd0;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_read       <= 1'b0;
         avm_writedata  <= 16'h0000;
         tick           <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state          <= S_WR_PL;
                  avm_chipselect <= 1'b1;
                  avm_write_n    <= 1'b0;
                  avm_address    <= 3'd2;
                  avm_writedata  <= PERIOD[15:0];
               end
            end
            S_WR_PL: begin
               state          <= S_WR_PH;
               avm_chipselect <= 1'b1;
               avm_write_n    <= 1'b0;
               avm_address    <= 3'd3;
               avm_writedata  <= PERIOD[31:16];
            end
            S_WR_PH: begin
               state          <= S_WR_CTRL;
               avm_chipselect <= 1'b1;
               avm_write_n    <= 1'b0;
               avm_address    <= 3'd1;
               avm_writedata  <= CTRL_INIT;
            end
            S_WR_CTRL: begin
               state   <= S_WAIT;
               running <= 1'b1;
`ifdef TIMER_DRV_POLL_EN
               poll_cnt <= 2'd0;
`endif
            end
            S_WAIT: begin
`ifdef TIMER_DRV_POLL_EN
               if (!enable) begin
                  state          <= S_WR_STOP;
                  avm_chipselect <= 1'b1;
                  avm_write_n    <= 1'b0;
                  avm_address    <= 3'd1;
                  avm_writedata  <= CTRL_STOP;
               end else if (poll_cnt == POLL_LAST) begin
                  state          <= S_RD;
                  avm_chipselect <= 1'b1;
                  avm_read       <= 1'b1;
                  poll_cnt       <= 2'd0;
               end else begin
                  poll_cnt <= poll_cnt + 2'd1;
               end
`else
               holdoff <= 1'b0;
               if (!enable) begin
                  state          <= S_WR_STOP;
                  avm_chipselect <= 1'b1;
                  avm_write_n    <= 1'b0;
                  avm_address    <= 3'd1;
                  avm_writedata  <= CTRL_STOP;
               end else if (irq && !holdoff) begin
                  state          <= S_RD;
                  avm_chipselect <= 1'b1;
                  avm_read       <= 1'b1;
               end
`endif
            end
            S_RD: begin
               state   <= S_RD_WAIT;
               lat_cnt <= 2'd0;
            end
            S_RD_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  if (avm_readdata[0]) begin
                     state          <= S_CLR;
                     avm_chipselect <= 1'b1;
                     avm_write_n    <= 1'b0;
                     tick           <= 1'b1;
                     tick_count     <= tick_count + TICK_W'(1);
                  end else begin
                     state <= S_WAIT;
`ifndef TIMER_DRV_POLL_EN
                     spurious <= 1'b1;
`endif
                  end
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            S_CLR: begin
               state <= S_WAIT;
`ifndef TIMER_DRV_POLL_EN
               holdoff <= 1'b1;
`endif
            end
            S_WR_STOP: begin
               state   <= S_IDLE;
               running <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avmm_timer_driver.sv
// tb/tb_avmm_timer_driver.sv - scoreboard bench for avmm_timer_driver with a timer responder model

module tb_avmm_timer_driver;

   logic        clk = 1'b0;
   logic        reset_n, enable, irq;
   logic [2:0]  avm_address;
   logic        avm_chipselect, avm_write_n, avm_read;
   logic [15:0] avm_writedata, avm_readdata;
   logic        tick, running, spurious;
   logic [3:0]  tick_count;

   always #5 clk = ~clk;

   avmm_timer_driver #(.TICK_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_read(avm_read),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .tick(tick), .tick_count(tick_count), .running(running), .spurious(spurious)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Responder: TO flag set on request, cleared by a status write; irq lags
   // TO by one cycle so it is still high in the cycle after the clear.
   logic        to_flag, to_set, irq_q, irq_force;
   logic [15:0] rd_data;
   assign irq          = irq_q | irq_force;
   assign avm_readdata = rd_data;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_flag <= 1'b0;
         irq_q   <= 1'b0;
         rd_data <= 16'h0000;
      end else begin
         irq_q <= to_flag;
         if (avm_chipselect && !avm_write_n && avm_address == 3'd0) to_flag <= 1'b0;
         else if (to_set) to_flag <= 1'b1;
         if (avm_chipselect && avm_read) rd_data <= {15'b0, to_flag};
      end
   end

   // Scoreboard: {read, write_n, address, data}; reads carry data 0.
   logic [20:0] exp_bus[$];
   logic [3:0]  exp_tick[$];
   logic [20:0] cmd;
   logic [3:0]  model_cnt;

   always @(negedge clk) begin
      if (reset_n) begin
         if (avm_chipselect) begin
            cmd = {avm_read, avm_write_n, avm_address, avm_read ? 16'h0000 : avm_writedata};
            if (exp_bus.size() == 0) check("bus_unexpected", 32'(cmd), 32'h1FFFFF);
            else check("bus_cmd", 32'(cmd), 32'(exp_bus.pop_front()));
         end
         if (tick) begin
            if (exp_tick.size() == 0) check("tick_unexpected", 32'd1, 32'd0);
            else check("tick_count", 32'(tick_count), 32'(exp_tick.pop_front()));
         end
      end
   end

   task automatic exp_wr(input logic [2:0] a, input logic [15:0] d);
      exp_bus.push_back({1'b0, 1'b0, a, d});
   endtask

   task automatic exp_rd();
      exp_bus.push_back({1'b1, 1'b1, 3'd0, 16'h0000});
   endtask

   task automatic wait_drain(input int limit);
      int waited = 0;
      while ((exp_bus.size() + exp_tick.size()) != 0 && waited < limit) begin
         @(negedge clk);
         waited++;
      end
      check("drain", 32'(exp_bus.size() + exp_tick.size()), 32'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic service_one();
      exp_rd();
      exp_wr(3'd0, 16'h0000);
      model_cnt = model_cnt + 4'd1;
      exp_tick.push_back(model_cnt);
      @(negedge clk) to_set = 1'b1;
      @(negedge clk) to_set = 1'b0;
      wait_drain(50);
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b0;
      to_set    = 1'b0;
      irq_force = 1'b0;
      model_cnt = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_cs", 32'(avm_chipselect), 32'd0);
      check("rst_write_n", 32'(avm_write_n), 32'd1);
      check("rst_read", 32'(avm_read), 32'd0);
      check("rst_addr", 32'(avm_address), 32'd0);
      check("rst_wdata", 32'(avm_writedata), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_tick_count", 32'(tick_count), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_spurious", 32'(spurious), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Init: three writes in consecutive cycles right after enable is sampled.
      exp_wr(3'd2, 16'h61A7);
      exp_wr(3'd3, 16'h0000);
      exp_wr(3'd1, 16'h0007);
      enable = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("init_cs", 32'(avm_chipselect), 32'd1);
      end
      check("running_during_ctrl", 32'(running), 32'd0);
      @(negedge clk);
      check("running_after_init", 32'(running), 32'd1);
      wait_drain(20);

      // First timeout, including the stale-irq holdoff cycle.
      service_one();
      check("tick_count_first", 32'(tick_count), 32'd1);

      // Spurious irq: status reads 0, no clear write, no tick.
      exp_rd();
      @(negedge clk) irq_force = 1'b1;
      @(negedge clk) irq_force = 1'b0;
      wait_drain(20);
      check("spurious_set", 32'(spurious), 32'd1);

      // 16 more timeouts: 17 total, count wraps 15 -> 0 and ends at 1.
      for (int i = 0; i < 16; i++) service_one();
      check("tick_count_wrap", 32'(tick_count), 32'(model_cnt));
      check("tick_count_final", 32'(tick_count), 32'd1);
      check("spurious_sticky", 32'(spurious), 32'd1);

      // enable low and irq high in the same WAIT cycle: stop wins, no read.
      exp_wr(3'd1, 16'h0008);
      @(negedge clk);
      enable    = 1'b0;
      irq_force = 1'b1;
      @(negedge clk) irq_force = 1'b0;
      wait_drain(20);
      check("running_after_stop", 32'(running), 32'd0);
      repeat (6) @(negedge clk);
      check("idle_after_stop", 32'(avm_chipselect), 32'd0);

      // Reset in the WR_PH cycle drops the bus at once; re-init starts over.
      exp_wr(3'd2, 16'h61A7);
      exp_wr(3'd3, 16'h0000);
      enable = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_cs", 32'(avm_chipselect), 32'd0);
      check("midrst_write_n", 32'(avm_write_n), 32'd1);
      check("midrst_spurious", 32'(spurious), 32'd0);
      check("midrst_tick_count", 32'(tick_count), 32'd0);
      check("midrst_queue", 32'(exp_bus.size()), 32'd0);
      model_cnt = 4'd0;
      @(negedge clk);
      exp_wr(3'd2, 16'h61A7);
      exp_wr(3'd3, 16'h0000);
      exp_wr(3'd1, 16'h0007);
      reset_n = 1'b1;
      wait_drain(20);
      check("running_reinit", 32'(running), 32'd1);
      service_one();
      check("tick_count_reinit", 32'(tick_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1);
   end

endmodule
